// File: rtl/tcm_trace_pkg.sv
// Shared types for the trace capture block: FSM states, trigger modes, readout latency.
// RD_LATENCY is the address-to-output round trip; the output buffer needs that many slots.
package tcm_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_POST    = 2'd2,
    ST_READOUT = 2'd3
  } trace_state_e;

  typedef enum logic [1:0] {
    TRIG_IMM   = 2'd0,
    TRIG_MATCH = 2'd1,
    TRIG_EXT   = 2'd2,
    TRIG_RSVD  = 2'd3
  } trig_mode_e;

  localparam int unsigned RD_LATENCY = 2;

endpackage

// File: rtl/tcm_trace_ram.sv
// Simple dual-port trace RAM: one write port, one registered synchronous read port.
// Read data appears the cycle after rd_en_i; no reset on the array so it maps onto block RAM.
module tcm_trace_ram #(
  parameter int unsigned AW = 8,
  parameter int unsigned W  = 66
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [W-1:0]  rd_data_o
);

  logic [W-1:0] mem [1 << AW];
  logic [W-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/tcm_trace_capture.sv
// Armable multi-channel trace buffer: captures probes into a circular RAM around a trigger,
// then streams the window oldest-first; first beat 2 cycles after READOUT, 1 beat/cycle, holds under stall.
module tcm_trace_capture
  import tcm_trace_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned POST_TRIG = DEPTH / 2,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(CHANNELS)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [CHANNELS-1:0]        probe_valid_i,
  input  logic [CHANNELS*DATA_W-1:0] probe_data_i,
  input  logic                       arm_i,
  input  logic                       abort_i,
  input  logic [1:0]                 trig_mode_i,
  input  logic [CW-1:0]              trig_chan_i,
  input  logic [DATA_W-1:0]          trig_value_i,
  input  logic                       ext_trig_i,
  output logic                       rd_valid_o,
  input  logic                       rd_ready_i,
  output logic [CHANNELS*DATA_W-1:0] rd_data_o,
  output logic [CHANNELS-1:0]        rd_mask_o,
  output logic                       rd_last_o,
  output logic [1:0]                 state_o,
  output logic [AW:0]                trig_pos_o
);

  localparam int unsigned DW = CHANNELS * DATA_W;
  localparam int unsigned EW = DW + CHANNELS;
  localparam logic [AW:0]   FILL_MAX  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   POS_CAP   = (AW+1)'(DEPTH - 1 - POST_TRIG);
  localparam logic [AW-1:0] POST_INIT = AW'(POST_TRIG);

  trace_state_e state_q, state_d;
  trig_mode_e   mode_q, mode_d;
  logic [CW-1:0]     chan_q, chan_d;
  logic [DATA_W-1:0] value_q, value_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]       fill_q, fill_d;
  logic [AW:0]       trig_pos_q, trig_pos_d;
  logic [AW-1:0]     post_cnt_q, post_cnt_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       rd_left_q, rd_left_d;
  logic              pend_q, pend_d;
  logic              pend_last_q, pend_last_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DW-1:0]       head_dat_q, head_dat_d, skid_dat_q, skid_dat_d;
  logic [CHANNELS-1:0] head_mask_q, head_mask_d, skid_mask_q, skid_mask_d;
  logic                head_last_q, head_last_d, skid_last_q, skid_last_d;

  logic              capture;
  logic              trig_hit;
  logic              chan_vld;
  logic [DATA_W-1:0] chan_dat;
  logic              pop;
  logic              issue;
  logic [2:0]        occ;
  logic [EW-1:0]     ram_rd_data;
  logic [CHANNELS-1:0] ram_mask;
  logic [DW-1:0]       ram_dat;

  assign capture  = (|probe_valid_i) && !abort_i &&
                    (state_q == ST_ARMED || state_q == ST_POST);
  assign pop      = (cnt_q != 2'd0) && rd_ready_i;
  // Slots already committed (buffered + in flight) after this cycle's pop.
  assign occ      = 3'(cnt_q) + 3'(pend_q) - 3'(pop);
  assign ram_mask = ram_rd_data[EW-1 -: CHANNELS];
  assign ram_dat  = ram_rd_data[DW-1:0];

  tcm_trace_ram #(
    .AW (AW),
    .W  (EW)
  ) u_ram (
    .clk_i     (clk_i),
    .wr_en_i   (capture),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i ({probe_valid_i, probe_data_i}),
    .rd_en_i   (issue),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (ram_rd_data)
  );

  always_comb begin
    chan_dat = probe_data_i[int'(chan_q) * DATA_W +: DATA_W];
    chan_vld = (int'(chan_q) < CHANNELS) && probe_valid_i[chan_q];
    case (mode_q)
      TRIG_IMM:   trig_hit = 1'b1;
      TRIG_MATCH: trig_hit = chan_vld && (chan_dat == value_q);
      TRIG_EXT:   trig_hit = ext_trig_i;
      default:    trig_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (arm_i) state_d = ST_ARMED;
        ST_ARMED:   if (capture && trig_hit)
                      state_d = (POST_TRIG == 0) ? ST_READOUT : ST_POST;
        ST_POST:    if (capture && post_cnt_q == AW'(1)) state_d = ST_READOUT;
        ST_READOUT: if (pop && head_last_q) state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mode_d      = mode_q;
    chan_d      = chan_q;
    value_d     = value_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    trig_pos_d  = trig_pos_q;
    post_cnt_d  = post_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    rd_left_d   = rd_left_q;
    pend_d      = 1'b0;
    pend_last_d = pend_last_q;
    cnt_d       = cnt_q;
    head_dat_d  = head_dat_q;
    head_mask_d = head_mask_q;
    head_last_d = head_last_q;
    skid_dat_d  = skid_dat_q;
    skid_mask_d = skid_mask_q;
    skid_last_d = skid_last_q;
    issue       = 1'b0;

    if (state_q == ST_IDLE && arm_i && !abort_i) begin
      mode_d     = trig_mode_e'(trig_mode_i);
      chan_d     = trig_chan_i;
      value_d    = trig_value_i;
      wr_ptr_d   = '0;
      fill_d     = '0;
      trig_pos_d = '0;
    end

    if (capture) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (fill_q != FILL_MAX) fill_d = fill_q + (AW+1)'(1);
      if (state_q == ST_ARMED && trig_hit) begin
        trig_pos_d = (fill_q < POS_CAP) ? fill_q : POS_CAP;
        post_cnt_d = POST_INIT;
      end else if (state_q == ST_POST) begin
        post_cnt_d = post_cnt_q - AW'(1);
      end
    end

    // The window is the last fill entries ending just before the next write slot.
    if (state_q != ST_READOUT && state_d == ST_READOUT) begin
      rd_ptr_d  = wr_ptr_d - fill_d[AW-1:0];
      rd_left_d = fill_d;
    end

    if (state_q == ST_READOUT && rd_left_q != '0 && occ < 3'(RD_LATENCY)) begin
      issue       = 1'b1;
      rd_ptr_d    = rd_ptr_q + AW'(1);
      rd_left_d   = rd_left_q - (AW+1)'(1);
      pend_d      = 1'b1;
      pend_last_d = (rd_left_q == (AW+1)'(1));
    end

    case (cnt_q)
      2'd0: if (pend_q) begin
        head_dat_d  = ram_dat;
        head_mask_d = ram_mask;
        head_last_d = pend_last_q;
        cnt_d       = 2'd1;
      end
      2'd1: begin
        if (pend_q && pop) begin
          head_dat_d  = ram_dat;
          head_mask_d = ram_mask;
          head_last_d = pend_last_q;
        end else if (pend_q) begin
          skid_dat_d  = ram_dat;
          skid_mask_d = ram_mask;
          skid_last_d = pend_last_q;
          cnt_d       = 2'd2;
        end else if (pop) begin
          cnt_d = 2'd0;
        end
      end
      default: if (pop) begin
        head_dat_d  = skid_dat_q;
        head_mask_d = skid_mask_q;
        head_last_d = skid_last_q;
        cnt_d       = 2'd1;
      end
    endcase

    if (abort_i) begin
      cnt_d     = 2'd0;
      pend_d    = 1'b0;
      rd_left_d = '0;
    end
  end

  always_comb begin
    rd_valid_o = (cnt_q != 2'd0);
    rd_last_o  = head_last_q && (cnt_q != 2'd0);
    rd_data_o  = head_dat_q;
    rd_mask_o  = head_mask_q;
    state_o    = state_q;
    trig_pos_o = trig_pos_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q      <= TRIG_IMM;
      chan_q      <= '0;
      value_q     <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      trig_pos_q  <= '0;
      post_cnt_q  <= '0;
      rd_ptr_q    <= '0;
      rd_left_q   <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      cnt_q       <= 2'd0;
      head_dat_q  <= '0;
      head_mask_q <= '0;
      head_last_q <= 1'b0;
      skid_dat_q  <= '0;
      skid_mask_q <= '0;
      skid_last_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      chan_q      <= chan_d;
      value_q     <= value_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      trig_pos_q  <= trig_pos_d;
      post_cnt_q  <= post_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_left_q   <= rd_left_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      cnt_q       <= cnt_d;
      head_dat_q  <= head_dat_d;
      head_mask_q <= head_mask_d;
      head_last_q <= head_last_d;
      skid_dat_q  <= skid_dat_d;
      skid_mask_q <= skid_mask_d;
      skid_last_q <= skid_last_d;
    end
  end

endmodule

// File: tb/tb_tcm_trace_capture.sv
// Bench for tcm_trace_capture (DEPTH=8, POST_TRIG=3, 2 channels): directed plan scenarios plus
// randomized captures checked against a queue-based model of the trigger window.
module tb_tcm_trace_capture;

  localparam int DEPTH = 8;
  localparam int POST  = 3;

  typedef struct packed {
    logic [1:0]  m;
    logic [63:0] d;
  } ent_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [1:0]  probe_valid_i = '0;
  logic [63:0] probe_data_i = '0;
  logic        arm_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [1:0]  trig_mode_i = '0;
  logic [0:0]  trig_chan_i = '0;
  logic [31:0] trig_value_i = '0;
  logic        ext_trig_i = 1'b0;
  logic        rd_valid_o;
  logic        rd_ready_i = 1'b0;
  logic [63:0] rd_data_o;
  logic [1:0]  rd_mask_o;
  logic        rd_last_o;
  logic [1:0]  state_o;
  logic [3:0]  trig_pos_o;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  tcm_trace_capture #(
    .DATA_W    (32),
    .DEPTH     (DEPTH),
    .CHANNELS  (2),
    .POST_TRIG (POST)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .probe_valid_i (probe_valid_i),
    .probe_data_i  (probe_data_i),
    .arm_i         (arm_i),
    .abort_i       (abort_i),
    .trig_mode_i   (trig_mode_i),
    .trig_chan_i   (trig_chan_i),
    .trig_value_i  (trig_value_i),
    .ext_trig_i    (ext_trig_i),
    .rd_valid_o    (rd_valid_o),
    .rd_ready_i    (rd_ready_i),
    .rd_data_o     (rd_data_o),
    .rd_mask_o     (rd_mask_o),
    .rd_last_o     (rd_last_o),
    .state_o       (state_o),
    .trig_pos_o    (trig_pos_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, 64'(state_o), 64'd0);
    chk({tag, "_valid"}, 64'(rd_valid_o), 64'd0);
    chk({tag, "_last"}, 64'(rd_last_o), 64'd0);
    chk({tag, "_data"}, rd_data_o, 64'd0);
    chk({tag, "_mask"}, 64'(rd_mask_o), 64'd0);
    chk({tag, "_tpos"}, 64'(trig_pos_o), 64'd0);
  endtask

  // pat 0: ch0 every cycle 0x100+4k; pat 1: ch1 on odd cycles 0xA0+k, ext with 3rd sample;
  // pat 2: random. rdy 0: always ready; 1: alternating; 2: random.
  task automatic run_capture(input int mode, input int chan, input logic [31:0] value,
                             input int pat, input int rdy_pat, input int stop_after,
                             output int nb, output logic [63:0] first_d, output logic [63:0] last_d);
    ent_t cq[$];
    ent_t e;
    int t = -1;
    int endi, start, n;
    bit closed = 0;
    bit h;
    int first_cyc = -1;
    bit stall = 0;
    bit rdy;
    logic [63:0] hd;
    logic [1:0] hm;
    logic hl;
    int beats = 0;

    nb = 0;
    first_d = '0;
    last_d = '0;
    trig_mode_i = mode[1:0];
    trig_chan_i = chan[0:0];
    trig_value_i = value;
    probe_valid_i = '0;
    rd_ready_i = 1'b0;
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    chk("armed_state", 64'(state_o), 64'd1);

    for (int cyc = 0; cyc < 300 && !closed; cyc++) begin
      case (pat)
        0: begin
          probe_valid_i = 2'b01;
          probe_data_i = {$urandom, 32'h100 + 32'(4 * cyc)};
          ext_trig_i = 1'b0;
        end
        1: begin
          probe_valid_i = (cyc % 2 == 1) ? 2'b10 : 2'b00;
          probe_data_i = {32'hA0 + 32'(cyc / 2), $urandom};
          ext_trig_i = (cyc == 5);
        end
        default: begin
          probe_valid_i = 2'($urandom_range(0, 3));
          probe_data_i = {32'h50 + 32'($urandom_range(0, 7)), 32'h50 + 32'($urandom_range(0, 7))};
          ext_trig_i = ($urandom_range(0, 7) == 0);
        end
      endcase
      if (|probe_valid_i) begin
        e.m = probe_valid_i;
        e.d = probe_data_i;
        cq.push_back(e);
        if (t < 0) begin
          case (mode)
            0: h = (cq.size() == 1);
            1: h = probe_valid_i[chan] && (probe_data_i[chan * 32 +: 32] == value);
            2: h = ext_trig_i;
            default: h = 0;
          endcase
          if (h) t = cq.size() - 1;
        end
        if (t >= 0 && cq.size() == t + POST + 1) closed = 1;
      end
      tick();
    end
    probe_valid_i = '0;
    ext_trig_i = 1'b0;
    chk("window_closed", 64'(closed), 64'd1);
    if (!closed) begin
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      return;
    end

    endi = t + POST;
    start = (endi - DEPTH + 1 > 0) ? endi - DEPTH + 1 : 0;
    n = endi - start + 1;
    chk("readout_state", 64'(state_o), 64'd3);
    chk("trig_pos", 64'(trig_pos_o), 64'(t - start));

    for (int cyc = 0; cyc < 200; cyc++) begin
      if (stop_after >= 0 && beats == stop_after) begin
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check_reset_outputs("midrst");
        break;
      end
      if (beats == n) break;
      probe_valid_i = 2'($urandom_range(0, 3));
      probe_data_i = {$urandom, $urandom};
      ext_trig_i = $urandom_range(0, 1) == 1;
      if (rd_valid_o && first_cyc < 0) first_cyc = cyc;
      if (stall) begin
        chk("hold_valid", 64'(rd_valid_o), 64'd1);
        chk("hold_data", rd_data_o, hd);
        chk("hold_mask", 64'(rd_mask_o), 64'(hm));
        chk("hold_last", 64'(rd_last_o), 64'(hl));
      end
      case (rdy_pat)
        0: rdy = 1;
        1: rdy = (cyc % 2 == 0);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      rd_ready_i = rdy;
      if (rd_valid_o && rdy) begin
        chk("beat_data", rd_data_o, cq[start + beats].d);
        chk("beat_mask", 64'(rd_mask_o), 64'(cq[start + beats].m));
        chk("beat_last", 64'(rd_last_o), 64'(beats == n - 1));
        if (beats == 0) first_d = rd_data_o;
        last_d = rd_data_o;
        beats++;
      end
      stall = rd_valid_o && !rdy;
      hd = rd_data_o;
      hm = rd_mask_o;
      hl = rd_last_o;
      tick();
    end
    rd_ready_i = 1'b0;
    probe_valid_i = '0;
    ext_trig_i = 1'b0;
    nb = beats;
    if (stop_after < 0) begin
      chk("beat_count", 64'(beats), 64'(n));
      chk("first_valid_lat", 64'(first_cyc), 64'd2);
      chk("idle_after", 64'(state_o), 64'd0);
      chk("valid_after", 64'(rd_valid_o), 64'd0);
    end
  endtask

  initial begin
    int nb;
    logic [63:0] fd, ld;
    bit seen;

    tick();
    tick();
    rst_i = 1'b0;
    tick();
    check_reset_outputs("reset");

    run_capture(0, 0, 32'h0, 0, 0, -1, nb, fd, ld);
    chk("imm_beats", 64'(nb), 64'd4);
    chk("imm_first", 64'(fd[31:0]), 64'h100);
    chk("imm_last", 64'(ld[31:0]), 64'h10C);
    chk("imm_tpos", 64'(trig_pos_o), 64'd0);

    run_capture(1, 0, 32'h120, 0, 0, -1, nb, fd, ld);
    chk("match_beats", 64'(nb), 64'd8);
    chk("match_first", 64'(fd[31:0]), 64'h110);
    chk("match_last", 64'(ld[31:0]), 64'h12C);
    chk("match_tpos", 64'(trig_pos_o), 64'd4);

    run_capture(1, 0, 32'h120, 0, 1, -1, nb, fd, ld);
    chk("bp_beats", 64'(nb), 64'd8);
    chk("bp_first", 64'(fd[31:0]), 64'h110);
    chk("bp_last", 64'(ld[31:0]), 64'h12C);

    run_capture(2, 1, 32'h0, 1, 0, -1, nb, fd, ld);
    chk("ext_beats", 64'(nb), 64'd6);
    chk("ext_first", 64'(fd[63:32]), 64'hA0);
    chk("ext_tpos", 64'(trig_pos_o), 64'd2);

    // abort while in POST, then arm and abort together
    trig_mode_i = 2'd0;
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    probe_valid_i = 2'b01;
    probe_data_i = 64'h55;
    tick();
    probe_valid_i = 2'b00;
    chk("post_state", 64'(state_o), 64'd2);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_state", 64'(state_o), 64'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      seen |= rd_valid_o;
      tick();
    end
    chk("abort_no_valid", 64'(seen), 64'd0);
    arm_i = 1'b1;
    abort_i = 1'b1;
    tick();
    arm_i = 1'b0;
    abort_i = 1'b0;
    chk("arm_abort_state", 64'(state_o), 64'd0);
    tick();
    chk("arm_abort_state2", 64'(state_o), 64'd0);

    run_capture(0, 0, 32'h0, 0, 2, -1, nb, fd, ld);
    chk("rearm_beats", 64'(nb), 64'd4);
    chk("rearm_tpos", 64'(trig_pos_o), 64'd0);

    for (int i = 0; i < 8; i++) begin
      run_capture(int'($urandom_range(0, 2)), int'($urandom_range(0, 1)),
                  32'h50 + 32'($urandom_range(0, 7)), 2, 2, -1, nb, fd, ld);
    end

    // reserved mode never triggers
    trig_mode_i = 2'd3;
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      probe_valid_i = 2'($urandom_range(1, 3));
      probe_data_i = {$urandom, $urandom};
      ext_trig_i = 1'b1;
      tick();
    end
    probe_valid_i = '0;
    ext_trig_i = 1'b0;
    chk("rsvd_state", 64'(state_o), 64'd1);
    chk("rsvd_valid", 64'(rd_valid_o), 64'd0);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;

    run_capture(1, 0, 32'h120, 0, 0, 2, nb, fd, ld);
    chk("midrst_beats", 64'(nb), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
